// File: rtl/snake_pkg.sv
// Shared constants, cell/colour codes and FSM states for the snake pixel renderer.
// Optional feature macro used by the top: GRID_LINES_EN.
package snake_pkg;

  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int CELLS   = GRID_W * GRID_H;
  localparam int CELL_SH = 4;
  localparam int H_VIS   = 640;
  localparam int V_VIS   = 480;
  localparam int ADDR_W  = 11;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BODY  = 2'd1,
    CELL_HEAD  = 2'd2,
    CELL_FOOD  = 2'd3
  } cell_t;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_BODY  = 3'b010;
  localparam logic [2:0] RGB_HEAD  = 3'b110;
  localparam logic [2:0] RGB_FOOD  = 3'b100;
  localparam logic [2:0] RGB_GRID  = 3'b001;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // y*40 + x without a multiplier: (y<<5) + (y<<3) + x
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
    logic [ADDR_W-1:0] yy;
    yy = {6'd0, y};
    return (yy << 5) + (yy << 3) + {5'd0, x};
  endfunction

endpackage

// File: rtl/snake_board_ram.sv
// 1200x2 simple dual-port board memory: one write port, one read-first registered read port.
module snake_board_ram
  import snake_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [1:0]        rdata
);

  logic [1:0] mem [0:CELLS-1];

  // Read samples the array before this cycle's write lands, so a collision returns old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/snake_pixel_render.sv
// Pixel stage after the VGA counters: board lookup, colour map, sync delay, board clear sequencer.
// Optional feature macro: GRID_LINES_EN (blue grid lines over empty visible cells).
module snake_pixel_render
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       clr_req,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [1:0] wr_data,
  output logic       clr_busy,
  output logic       HS,
  output logic       VS,
  output logic       R,
  output logic       G,
  output logic       B
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [1:0]        ram_wdata;

  logic              vis_now;
  logic [ADDR_W-1:0] rd_addr_now;
  logic [ADDR_W-1:0] rd_addr1;
  logic              vis1, vis2, hs1, hs2, vs1, vs2;
  logic [1:0]        cell2;
  logic [2:0]        pix_rgb;
`ifdef GRID_LINES_EN
  logic              grid1, grid2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_cnt  <= '0;
      clr_busy <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_req) begin
            clr_cnt <= '0;
          end else if (clr_cnt == ADDR_W'(CELLS - 1)) begin
            state    <= ST_RUN;
            clr_busy <= 1'b0;
            clr_cnt  <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          if (clr_req) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            clr_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  // The clear sequencer owns the write port; game writes are dropped until it finishes.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_cnt;
    ram_wdata = CELL_EMPTY;
    if (state == ST_CLEAR) begin
      ram_we = 1'b1;
    end else if (wr_en && (wr_x < 6'(GRID_W)) && (wr_y < 5'(GRID_H))) begin
      ram_we    = 1'b1;
      ram_waddr = cell_addr(wr_x, wr_y);
      ram_wdata = wr_data;
    end
  end

  assign vis_now     = (h_count < 10'(H_VIS)) && (v_count < 10'(V_VIS));
  assign rd_addr_now = vis_now ? cell_addr(6'(h_count >> CELL_SH), 5'(v_count >> CELL_SH)) : '0;

  snake_board_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (pix_en),
    .raddr (rd_addr1),
    .rdata (cell2)
  );

  always_comb begin
    pix_rgb = RGB_BLACK;
    if (vis2 && !clr_busy) begin
      case (cell_t'(cell2))
        CELL_BODY: pix_rgb = RGB_BODY;
        CELL_HEAD: pix_rgb = RGB_HEAD;
        CELL_FOOD: pix_rgb = RGB_FOOD;
        default: begin
`ifdef GRID_LINES_EN
          if (grid2) pix_rgb = RGB_GRID;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vis1     <= 1'b0;
      vis2     <= 1'b0;
      hs1      <= 1'b1;
      hs2      <= 1'b1;
      vs1      <= 1'b1;
      vs2      <= 1'b1;
      rd_addr1 <= '0;
      HS       <= 1'b1;
      VS       <= 1'b1;
      R        <= 1'b0;
      G        <= 1'b0;
      B        <= 1'b0;
`ifdef GRID_LINES_EN
      grid1    <= 1'b0;
      grid2    <= 1'b0;
`endif
    end else if (pix_en) begin
      vis1      <= vis_now;
      hs1       <= hs_in;
      vs1       <= vs_in;
      rd_addr1  <= rd_addr_now;
      vis2      <= vis1;
      hs2       <= hs1;
      vs2       <= vs1;
      HS        <= hs2;
      VS        <= vs2;
      {R, G, B} <= pix_rgb;
`ifdef GRID_LINES_EN
      grid1     <= (h_count[3:0] == 4'd0) || (v_count[3:0] == 4'd0);
      grid2     <= grid1;
`endif
    end
  end

endmodule
